// File: rtl/hevc_sched_pkg.sv
// Shared scheduler types: FSM state encoding and tag-width helper.
package hevc_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } sched_state_t;

   // Width of an index selecting one of n fluxes (never narrower than 1 bit).
   function automatic int unsigned tag_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority picker: searches start+1, start+2, ...
// wrapping modulo N, with start itself checked last.
module rr_prio_pick #(
   parameter int unsigned N = 2,
   parameter int unsigned W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         valid,
   output logic [W-1:0] idx,
   output logic [N-1:0] onehot
);

   // First requester after start in circular order wins.
   always_comb begin
      logic [31:0] k;
      k      = '0;
      valid  = 1'b0;
      idx    = '0;
      onehot = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         k = (32'(start) + 32'(i)) % 32'(N);
         if (!valid && req[k]) begin
            valid = 1'b1;
            idx   = W'(k);
         end
      end
      if (valid) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/flux_rr_scheduler.sv
// Round-robin scheduler sharing one actor datapath among FLUX tagged fluxes,
// holding a flux for up to BURST consecutive fires before rotating.
module flux_rr_scheduler
   import hevc_sched_pkg::*;
#(
   parameter int unsigned FLUX      = 2,
   parameter int unsigned BURST     = 8,
   parameter int unsigned TAG_WIDTH = tag_width(FLUX)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [FLUX-1:0]      req,
   input  logic                 fire,
   input  logic                 last,
   output logic                 gnt_valid,
   output logic [TAG_WIDTH-1:0] gnt_tag,
   output logic [FLUX-1:0]      gnt_onehot,
   output logic                 locked,
   output logic                 err
);

   localparam int unsigned        BW        = $clog2(BURST + 1);
   localparam logic [BW-1:0]      BCNT_LAST = BW'(BURST - 1);
   localparam logic [TAG_WIDTH-1:0] PTR_RST = TAG_WIDTH'(FLUX - 1);

   sched_state_t         state_q, state_d;
   logic [TAG_WIDTH-1:0] ptr_q, ptr_d;
   logic [TAG_WIDTH-1:0] cur_q, cur_d;
   logic [BW-1:0]        bcnt_q, bcnt_d;
   logic                 err_q, err_d;

   logic                 pick_valid;
   logic [TAG_WIDTH-1:0] pick_idx;
   logic [FLUX-1:0]      pick_onehot;
   logic                 hold;
   logic                 burst_end;

   rr_prio_pick #(
      .N (FLUX),
      .W (TAG_WIDTH)
   ) u_pick (
      .req    (req),
      .start  (ptr_q),
      .valid  (pick_valid),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   assign hold      = (state_q == LOCK) && req[cur_q];
   assign burst_end = last || (bcnt_q == BCNT_LAST);
   assign locked    = (state_q == LOCK);
   assign err       = err_q;

   // Grant: held flux keeps priority while it still requests, else rotate.
   always_comb begin
      gnt_valid  = hold | pick_valid;
      gnt_tag    = hold ? cur_q : pick_idx;
      gnt_onehot = '0;
      if (hold) begin
         gnt_onehot[cur_q] = 1'b1;
      end else begin
         gnt_onehot = pick_onehot;
      end
   end

   // Next-state: burst accounting, rotation and protocol error capture.
   // With no requester at all the lock is kept so a stalled flux resumes.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cur_d   = cur_q;
      bcnt_d  = bcnt_q;
      err_d   = err_q;
      if (fire && !gnt_valid) begin
         err_d = 1'b1;
      end else if (fire) begin
         ptr_d = gnt_tag;
         if ((state_q == LOCK) && !hold) begin
            state_d = IDLE;
            bcnt_d  = '0;
         end else if (burst_end) begin
            state_d = IDLE;
            bcnt_d  = '0;
         end else if (state_q == IDLE) begin
            state_d = LOCK;
            cur_d   = gnt_tag;
            bcnt_d  = BW'(1);
         end else begin
            bcnt_d = bcnt_q + BW'(1);
         end
      end else if ((state_q == LOCK) && !hold && (req != '0)) begin
         state_d = IDLE;
         bcnt_d  = '0;
      end
   end

   // State register with asynchronous reset; flux 0 wins first after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= PTR_RST;
         cur_q   <= '0;
         bcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cur_q   <= cur_d;
         bcnt_q  <= bcnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Self-checking bench for flux_rr_scheduler (FLUX=4, BURST=4).
module tb_flux_rr_scheduler;

   localparam int NF = 4;
   localparam int NB = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NF-1:0] req = '0;
   logic          fire = 1'b0;
   logic          last = 1'b0;
   logic          gnt_valid;
   logic [1:0]    gnt_tag;
   logic [NF-1:0] gnt_onehot;
   logic          locked;
   logic          err;

   int nvec = 0;
   int nmis = 0;

   flux_rr_scheduler #(
      .FLUX  (NF),
      .BURST (NB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .fire       (fire),
      .last       (last),
      .gnt_valid  (gnt_valid),
      .gnt_tag    (gnt_tag),
      .gnt_onehot (gnt_onehot),
      .locked     (locked),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NF-1:0] r;
      bit            f;
      bit            l;
      bit            ev;
      int            et;
      bit            el;
      bit            ee;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input bit ev, input int et, input bit el, input bit ee);
      int eoh;
      eoh = ev ? (1 << et) : 0;
      chk({nm, ".valid"},  int'(gnt_valid),  int'(ev));
      chk({nm, ".tag"},    int'(gnt_tag),    ev ? et : 0);
      chk({nm, ".onehot"}, int'(gnt_onehot), eoh);
      chk({nm, ".locked"}, int'(locked),     int'(el));
      chk({nm, ".err"},    int'(err),        int'(ee));
   endtask

   // Behavioural reference: who holds the datapath, how many fires it had.
   int m_ptr, m_hold, m_run;
   bit m_err;
   int wait_cnt[NF];
   int max_wait;

   task automatic m_reset();
      m_ptr  = NF - 1;
      m_hold = -1;
      m_run  = 0;
      m_err  = 0;
      for (int k = 0; k < NF; k++) wait_cnt[k] = 0;
   endtask

   function automatic int m_grant(input logic [NF-1:0] r);
      if (m_hold >= 0 && r[m_hold]) return m_hold;
      for (int k = 1; k <= NF; k++) begin
         if (r[(m_ptr + k) % NF]) return (m_ptr + k) % NF;
      end
      return -1;
   endfunction

   task automatic m_step(input logic [NF-1:0] r, input bit f, input bit l);
      int g;
      g = m_grant(r);
      for (int k = 0; k < NF; k++) begin
         if (!r[k]) wait_cnt[k] = 0;
         else if (f && g >= 0) begin
            if (k == g) wait_cnt[k] = 0;
            else wait_cnt[k]++;
            if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
         end
      end
      if (f && g < 0) begin
         m_err = 1;
      end else if (f) begin
         m_ptr = g;
         if (m_hold >= 0 && g != m_hold) begin
            m_hold = -1;
            m_run  = 0;
         end else begin
            m_run++;
            if (l || m_run == NB) begin
               m_hold = -1;
               m_run  = 0;
            end else begin
               m_hold = g;
            end
         end
      end else if (r != '0 && m_hold >= 0 && !r[m_hold]) begin
         m_hold = -1;
         m_run  = 0;
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1; req = '0; fire = 1'b0; last = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_reset();
   endtask

   task automatic add(input logic [3:0] r, input bit f, input bit l,
                      input bit ev, input int et, input bit el, input bit ee);
      vec_t v;
      v.r = r; v.f = f; v.l = l; v.ev = ev; v.et = et; v.el = el; v.ee = ee;
      vq.push_back(v);
   endtask

   initial begin
      logic [NF-1:0] rr;
      int            g;

      // Equal fair bursts on two fluxes: 0,0,0,0,1,1,1,1,0
      for (int i = 0; i < 4; i++) add(4'b0011, 1, 0, 1, 0, i != 0, 0);
      for (int i = 0; i < 4; i++) add(4'b0011, 1, 0, 1, 1, i != 0, 0);
      add(4'b0011, 1, 0, 1, 0, 0, 0);
      // Held flux drops out: other tag granted, lock released; then last each fire
      add(4'b1010, 1, 1, 1, 1, 1, 0);
      add(4'b1010, 1, 1, 1, 3, 0, 0);
      add(4'b1010, 1, 1, 1, 1, 0, 0);
      add(4'b1010, 1, 1, 1, 3, 0, 0);
      // Lock on 0 then req[0] drops: same-cycle switch to 1, then IDLE
      add(4'b0011, 1, 0, 1, 0, 0, 0);
      add(4'b0011, 1, 0, 1, 0, 1, 0);
      add(4'b0010, 0, 0, 1, 1, 1, 0);
      add(4'b0011, 0, 0, 1, 1, 0, 0);
      add(4'b0011, 0, 1, 1, 1, 0, 0);
      // Fire with nothing granted: sticky err, ptr untouched
      add(4'b0000, 1, 0, 0, 0, 0, 0);
      add(4'b0000, 0, 0, 0, 0, 0, 1);
      add(4'b0011, 0, 0, 1, 1, 0, 1);
      // No requester at all keeps the lock
      add(4'b0011, 1, 0, 1, 1, 0, 1);
      add(4'b0000, 0, 0, 0, 0, 1, 1);
      add(4'b0011, 0, 0, 1, 1, 1, 1);

      reset_dut();
      #1;
      chk_out("reset", 0, 0, 0, 0);

      foreach (vq[i]) begin
         @(negedge clk);
         req = vq[i].r; fire = vq[i].f; last = vq[i].l;
         #1;
         chk_out($sformatf("vec%0d", i), vq[i].ev, vq[i].et, vq[i].el, vq[i].ee);
      end

      // Asynchronous reset mid-burst: outputs recover before any clock edge
      @(negedge clk);
      req = 4'b0011; fire = 1'b1; last = 1'b0;
      #1;
      chk_out("preburst", 1, 1, 1, 1);
      @(negedge clk);
      fire = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk_out("async_rst", 1, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      fire = 1'b1;
      #1;
      chk_out("post_rst", 1, 0, 0, 0);
      @(negedge clk);
      fire = 1'b0;
      #1;
      chk_out("post_rst_lock", 1, 0, 1, 0);

      // Randomised run against the reference model
      reset_dut();
      max_wait = 0;
      rr = 4'b1111;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) rr[$urandom_range(0, NF - 1)] ^= 1'b1;
         if ($urandom_range(0, 63) == 0) rr = '0;
         if ($urandom_range(0, 63) == 0) rr = 4'b1111;
         req  = rr;
         fire = ($urandom_range(0, 9) < 7);
         last = ($urandom_range(0, 9) < 2);
         #1;
         g = m_grant(rr);
         chk_out("rand", g >= 0, g, m_hold >= 0, m_err);
         m_step(rr, fire, last);
      end
      chk("starve_bound_ok", int'(max_wait <= (NF - 1) * NB), 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/flux_rr_scheduler.md
FLUX_RR_SCHEDULER -- requirements
Module: flux_rr_scheduler

Interface
REQ-001 Parameter FLUX, default 2, number of tagged fluxes sharing one actor datapath; legal range 2..16.
REQ-002 Parameter BURST, default 8, maximum consecutive fires granted to one flux before rotation; legal range 1..64.
REQ-003 Parameter TAG_WIDTH, default $clog2(FLUX), width of the flux tag.
REQ-004 Ports: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req  in  FLUX  per-flux eligibility: FIFO data available, output not full, actor state ready.
REQ-008 fire  in  1  datapath consumed one token on the granted tag this cycle.
REQ-009 last  in  1  qualifies fire; the token closes a unit (row or block end), forcing rotation.
REQ-010 gnt_valid  out  1  a grant is asserted this cycle.
REQ-011 gnt_tag  out  TAG_WIDTH  granted flux index; 0 when gnt_valid=0.
REQ-012 gnt_onehot  out  FLUX  one-hot grant; all zero when gnt_valid=0.
REQ-013 locked  out  1  scheduler is holding the current flux (state LOCK).
REQ-014 err  out  1  sticky protocol error flag.

Function
REQ-015 Grant outputs are combinational from req and registered state; zero-cycle latency from req to grant.
REQ-016 Registers: ptr (TAG_WIDTH, last served flux), cur (TAG_WIDTH, held flux), bcnt ($clog2(BURST+1) bits), state {IDLE, LOCK}, err.
REQ-017 IDLE: grant the first flux with req high, searching ptr+1, ptr+2, ... wrapping modulo FLUX; ptr itself last.
REQ-018 LOCK: if req[cur]=1, grant cur; otherwise grant per REQ-017 search.
REQ-019 No req bit high: gnt_valid=0, state and counters unchanged.
REQ-020 On fire with gnt_valid=1: ptr <= gnt_tag.
REQ-021 Fire with last=1, or bcnt reaching BURST-1 on a fire (BURST=1: every fire): next state IDLE, bcnt <= 0.
REQ-022 Other fire from IDLE: state <= LOCK, cur <= gnt_tag, bcnt <= 1.
REQ-023 Other fire in LOCK on cur: bcnt <= bcnt+1, stay LOCK.
REQ-024 In LOCK with req[cur]=0: state <= IDLE, bcnt <= 0 at next edge, regardless of fire on another tag; a fire on another tag follows REQ-020 only.
REQ-025 fire=1 with gnt_valid=0: err <= 1, no other register changes; err clears only on reset.
REQ-026 last=1 with fire=0 is ignored.
REQ-027 Exactly one gnt_onehot bit equals gnt_tag whenever gnt_valid=1; grant never selects a flux with req=0.
REQ-028 Fairness: with all req held high and last=0, each flux receives exactly BURST consecutive fires in index order.

Reset
REQ-029 rst asserted: state=IDLE, ptr=FLUX-1 (flux 0 wins first), cur=0, bcnt=0, err=0, effective immediately without clock.
REQ-030 rst asserted mid-burst abandons the lock; first grant after release follows REQ-029 values.

Structure
REQ-031 Shared package hevc_sched_pkg holds the state enum (IDLE, LOCK) and a tag-width function; FLUX and BURST stay module parameters.
REQ-032 One sub-module, rr_prio_pick (combinational rotating-priority picker: req, start index -> valid, index, one-hot), is instantiated once.
REQ-033 No memories; all state in flip-flops.

Verification
REQ-034 FLUX=2, BURST=4, req=11, fire every cycle, last=0 -> tags 0,0,0,0,1,1,1,1,0...
REQ-035 FLUX=4, BURST=8, req=1010, fire with last=1 each cycle -> tags 1,3,1,3; locked stays 0.
REQ-036 FLUX=2, BURST=8, locked on 0 after 3 fires, req[0] drops -> same cycle gnt_tag=1; next cycle state IDLE, bcnt=0.
REQ-037 fire=1 while req=00 -> err=1 next edge, ptr unchanged; err remains 1 until rst.
REQ-038 rst pulsed asynchronously mid-burst (bcnt=5) -> outputs return to reset values before next edge; next grant with req=11 is tag 0.
REQ-039 Random req/fire/last, 10k cycles, FLUX=4 -> assertions REQ-027 hold, no flux starves longer than (FLUX-1)*BURST fires while req held.
